// File: rtl/ldlt_pkg.sv
// Shared types, default widths and fixed-point helpers for the LDL^T factoriser.
package ldlt_pkg;

    localparam int unsigned DATA_LEN_DEF = 34;
    localparam int unsigned FRACTION_DEF = 16;
    localparam int unsigned MAX_LEN      = 64;

    typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;
    typedef enum logic [1:0] {PH_LOAD, PH_MAC, PH_WAIT} phase_t;

    // Operands arrive sign-extended to MAX_LEN; callers truncate the result to their width.
    function automatic logic signed [MAX_LEN-1:0] fx_mul(
        input logic signed [MAX_LEN-1:0] a,
        input logic signed [MAX_LEN-1:0] b,
        input int unsigned               frac
    );
        logic signed [2*MAX_LEN-1:0] p;
        p = (2*MAX_LEN)'(a) * (2*MAX_LEN)'(b);
        p = p >>> frac;
        return p[MAX_LEN-1:0];
    endfunction

    function automatic int unsigned tri_idx(input int unsigned i, input int unsigned j);
        return i * (i + 1) / 2 + j;
    endfunction

endpackage

// File: rtl/ldlt_fx_div.sv
// Sequential signed restoring divider: (num <<< FRACTION) / den, toward zero, den=0 gives 0.
module ldlt_fx_div #(
    parameter int unsigned DATA_LEN = 34,
    parameter int unsigned FRACTION = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic signed [DATA_LEN-1:0] i_num,
    input  logic signed [DATA_LEN-1:0] i_den,
    output logic                       o_done,
    output logic signed [DATA_LEN-1:0] o_quot
);
    localparam int unsigned DW    = 2 * DATA_LEN;
    localparam int unsigned CNT_W = $clog2(DW + 1);

    logic                r_busy;
    logic                r_done;
    logic                r_neg;
    logic [CNT_W-1:0]    r_cnt;
    logic [DW-1:0]       r_dvd;
    logic [DATA_LEN-1:0] r_rem;
    logic [DATA_LEN-1:0] r_den;
    logic [DATA_LEN-1:0] r_quo;

    logic [DATA_LEN-1:0] w_num_mag;
    logic [DATA_LEN-1:0] w_den_mag;
    logic [DATA_LEN:0]   w_sh;
    logic                w_ge;

    assign w_num_mag = i_num[DATA_LEN-1] ? -i_num : i_num;
    assign w_den_mag = i_den[DATA_LEN-1] ? -i_den : i_den;
    assign w_sh      = {r_rem, r_dvd[DW-1]};
    assign w_ge      = (w_sh >= {1'b0, r_den});

    // Only the low DATA_LEN quotient bits are kept; the sign is applied mod 2^DATA_LEN.
    assign o_done = r_done;
    assign o_quot = r_neg ? -r_quo : r_quo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_neg  <= 1'b0;
            r_cnt  <= '0;
            r_dvd  <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_quo  <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (i_start) begin
                    r_neg <= i_num[DATA_LEN-1] ^ i_den[DATA_LEN-1];
                    r_dvd <= {{(DATA_LEN-FRACTION){1'b0}}, w_num_mag, {FRACTION{1'b0}}};
                    r_den <= w_den_mag;
                    r_rem <= '0;
                    r_quo <= '0;
                    r_cnt <= CNT_W'(DW);
                    if (i_den == '0) begin
                        r_done <= 1'b1;
                    end else begin
                        r_busy <= 1'b1;
                    end
                end
            end else begin
                r_rem <= w_ge ? DATA_LEN'(w_sh - {1'b0, r_den}) : w_sh[DATA_LEN-1:0];
                r_dvd <= r_dvd << 1;
                r_quo <= {r_quo[DATA_LEN-2:0], w_ge};
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ldlt_decomp.sv
// Streaming in-place LDL^T factoriser: load lower triangle, factorise, stream L/D out.
module ldlt_decomp
    import ldlt_pkg::*;
#(
    parameter int unsigned DATA_LEN = DATA_LEN_DEF,
    parameter int unsigned NODE_NUM = 1,
    parameter int unsigned FRACTION = FRACTION_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic signed [DATA_LEN-1:0] i_data,
    output logic                       o_ready,
    output logic                       o_valid,
    output logic signed [DATA_LEN-1:0] o_data
);
    localparam int unsigned N     = 6 * NODE_NUM;
    localparam int unsigned T     = N * (N + 1) / 2;
    localparam int unsigned IDX_W = $clog2(T);
    localparam int unsigned CW    = $clog2(N) + 1;

    state_t                     r_state, w_state_nxt;
    phase_t                     r_phase;
    logic signed [DATA_LEN-1:0] r_mem [T];
    logic [IDX_W-1:0]           r_cnt;
    logic [CW-1:0]              r_i, r_j, r_k;
    logic signed [DATA_LEN-1:0] r_acc;

    logic [IDX_W-1:0]           w_idx_ij, w_idx_jk, w_idx_kk, w_idx_ik, w_idx_jj;
    logic signed [DATA_LEN-1:0] w_t1, w_term, w_quot, w_wr_data;
    logic                       w_capture, w_load_last, w_out_last;
    logic                       w_div_start, w_div_done, w_elem_done, w_comp_done;

    assign w_idx_ij = IDX_W'(tri_idx(32'(r_i), 32'(r_j)));
    assign w_idx_jk = IDX_W'(tri_idx(32'(r_j), 32'(r_k)));
    assign w_idx_kk = IDX_W'(tri_idx(32'(r_k), 32'(r_k)));
    assign w_idx_ik = IDX_W'(tri_idx(32'(r_i), 32'(r_k)));
    assign w_idx_jj = IDX_W'(tri_idx(32'(r_j), 32'(r_j)));

    // For j == i the L_jk and L_ik reads coincide, so one MAC form serves both cases.
    assign w_t1   = DATA_LEN'(fx_mul(MAX_LEN'(r_mem[w_idx_jk]), MAX_LEN'(r_mem[w_idx_kk]), FRACTION));
    assign w_term = DATA_LEN'(fx_mul(MAX_LEN'(w_t1), MAX_LEN'(r_mem[w_idx_ik]), FRACTION));

    assign w_capture   = (r_state == IDLE) && i_start;
    assign w_load_last = w_capture && (r_cnt == IDX_W'(T - 1));
    assign w_out_last  = (r_state == OUTPUT) && (r_cnt == IDX_W'(T - 1));
    assign w_div_start = (r_state == COMPUTE) && (r_phase == PH_MAC) && (r_k == r_j) && (r_j != r_i);
    assign w_elem_done = (r_state == COMPUTE) &&
                         (((r_phase == PH_MAC) && (r_k == r_j) && (r_j == r_i)) ||
                          ((r_phase == PH_WAIT) && w_div_done));
    assign w_comp_done = w_elem_done && (r_i == CW'(N - 1)) && (r_j == r_i);
    assign w_wr_data   = (r_phase == PH_WAIT) ? w_quot : r_acc;

    assign o_ready = (r_state == IDLE);
    assign o_valid = (r_state == OUTPUT);
    assign o_data  = o_valid ? r_mem[r_cnt] : '0;

    ldlt_fx_div #(
        .DATA_LEN(DATA_LEN),
        .FRACTION(FRACTION)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_start(w_div_start),
        .i_num  (r_acc),
        .i_den  (r_mem[w_idx_jj]),
        .o_done (w_div_done),
        .o_quot (w_quot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_load_last) w_state_nxt = COMPUTE;
            COMPUTE: if (w_comp_done) w_state_nxt = OUTPUT;
            OUTPUT:  if (w_out_last)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_capture)        r_mem[r_cnt]    <= i_data;
        else if (w_elem_done) r_mem[w_idx_ij] <= w_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_LOAD;
            r_cnt   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_capture) r_cnt <= w_load_last ? '0 : r_cnt + IDX_W'(1);
                    if (w_load_last) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_phase <= PH_LOAD;
                    end
                end
                COMPUTE: begin
                    if (w_elem_done) begin
                        r_phase <= PH_LOAD;
                        if (r_j == r_i) begin
                            r_i <= r_i + CW'(1);
                            r_j <= '0;
                        end else begin
                            r_j <= r_j + CW'(1);
                        end
                    end else begin
                        case (r_phase)
                            PH_LOAD: begin
                                r_acc   <= r_mem[w_idx_ij];
                                r_k     <= '0;
                                r_phase <= PH_MAC;
                            end
                            PH_MAC: begin
                                if (r_k == r_j) begin
                                    r_phase <= PH_WAIT;
                                end else begin
                                    r_acc <= r_acc - w_term;
                                    r_k   <= r_k + CW'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                OUTPUT: begin
                    r_cnt <= w_out_last ? '0 : r_cnt + IDX_W'(1);
                    if (w_out_last) begin
                        r_i <= '0;
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ldlt_decomp.sv
// Self-checking bench for ldlt_decomp against a plain-arithmetic LDL^T reference model.
module tb_ldlt_decomp;

    typedef logic signed [33:0] word_t;
    typedef word_t mat_t [21];

    logic  clk;
    logic  rst_n;
    logic  i_start;
    word_t i_data;
    logic  o_ready;
    logic  o_valid;
    word_t o_data;

    int n_checks = 0;
    int n_pass   = 0;

    ldlt_decomp #(
        .DATA_LEN(34),
        .NODE_NUM(1),
        .FRACTION(16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_start(i_start),
        .i_data (i_data),
        .o_ready(o_ready),
        .o_valid(o_valid),
        .o_data (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ix(input int i, input int j);
        return i * (i + 1) / 2 + j;
    endfunction

    function automatic word_t m_mul(input word_t a, input word_t b);
        logic signed [67:0] pa, pb, p;
        pa = a;
        pb = b;
        p  = pa * pb;
        return p[49:16];
    endfunction

    function automatic word_t m_div(input word_t a, input word_t d);
        logic signed [67:0] n, dd, q;
        if (d == 0) return '0;
        n  = a;
        n  = n <<< 16;
        dd = d;
        q  = n / dd;
        return q[33:0];
    endfunction

    function automatic void model(input mat_t a, output mat_t e);
        word_t L [6][6];
        word_t D [6];
        word_t acc;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j <= i; j++) begin
                acc = a[ix(i, j)];
                for (int k = 0; k < j; k++)
                    acc = acc - m_mul(m_mul(L[j][k], D[k]), L[i][k]);
                if (j < i) begin
                    L[i][j]     = m_div(acc, D[j]);
                    e[ix(i, j)] = L[i][j];
                end else begin
                    D[i]        = acc;
                    e[ix(i, j)] = acc;
                end
            end
        end
    endfunction

    function automatic word_t rand_word();
        return word_t'({$urandom(), $urandom()});
    endfunction

    function automatic word_t rand_small(input int unsigned span);
        int v;
        v = int'($urandom_range(2 * span)) - int'(span);
        return word_t'(v);
    endfunction

    function automatic mat_t diag_mat(input word_t step, input bit ramp);
        mat_t m;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j <= i; j++)
                m[ix(i, j)] = (i == j) ? (ramp ? step * word_t'(i + 1) : step) : '0;
        return m;
    endfunction

    function automatic mat_t coupled_mat();
        mat_t m;
        m = diag_mat(word_t'(34'h20000), 1'b0);
        m[ix(1, 0)] = word_t'(34'h10000);
        return m;
    endfunction

    task automatic load_matrix(input mat_t a, input int pause_after, input int pause_len,
                               output bit ready_ok);
        ready_ok = 1'b1;
        for (int w = 0; w < 21; w++) begin
            if (w == pause_after) begin
                i_start = 1'b0;
                i_data  = rand_word();
                repeat (pause_len) begin
                    @(negedge clk);
                    if (o_ready !== 1'b1) ready_ok = 1'b0;
                end
            end
            if (o_ready !== 1'b1) ready_ok = 1'b0;
            i_start = 1'b1;
            i_data  = a[w];
            @(negedge clk);
        end
        i_start = 1'b0;
        i_data  = '0;
        if (o_ready !== 1'b0) ready_ok = 1'b0;
    endtask

    task automatic collect(input string name, input mat_t e);
        int waited = 0;
        while (o_valid !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (o_valid !== 1'b1) begin
            $display("FAIL %s_latency: o_valid=%b after %0d cycles, required 1", name, o_valid, waited);
            return;
        end
        n_pass++;
        for (int w = 0; w < 21; w++) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== e[w] || o_ready !== 1'b0)
                $display("FAIL %s_word[%0d]: valid=%b data=%h ready=%b, required valid=1 data=%h ready=0",
                         name, w, o_valid, o_data, o_ready, e[w]);
            else
                n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (o_valid !== 1'b0 || o_data !== '0 || o_ready !== 1'b1)
            $display("FAIL %s_end: valid=%b data=%h ready=%b, required valid=0 data=0 ready=1",
                     name, o_valid, o_data, o_ready);
        else
            n_pass++;
    endtask

    task automatic run_matrix(input string name, input mat_t a, input int pause_after);
        mat_t e;
        bit   ok;
        model(a, e);
        load_matrix(a, pause_after, 3, ok);
        n_checks++;
        if (!ok) $display("FAIL %s_ready: o_ready handshake wrong during load, required 1 then 0", name);
        else     n_pass++;
        collect(name, e);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== '0)
            $display("FAIL reset: ready=%b valid=%b data=%h, required 1 0 0", o_ready, o_valid, o_data);
        else
            n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        run_matrix("identity", diag_mat(word_t'(34'h10000), 1'b0), -1);
    endtask

    task automatic test_diag_ramp();
        run_matrix("diag_ramp", diag_mat(word_t'(34'h10000), 1'b1), -1);
    endtask

    task automatic test_coupled();
        run_matrix("coupled", coupled_mat(), -1);
    endtask

    task automatic test_pause();
        run_matrix("pause", coupled_mat(), 7);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int waited = 0;
        load_matrix(diag_mat(word_t'(34'h10000), 1'b0), -1, 0, ok);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== '0)
            $display("FAIL reset_compute: ready=%b valid=%b data=%h, required 1 0 0", o_ready, o_valid, o_data);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_matrix("after_reset", diag_mat(word_t'(34'h10000), 1'b0), -1);
        load_matrix(coupled_mat(), -1, 0, ok);
        while (o_valid !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== '0)
            $display("FAIL reset_output: ready=%b valid=%b data=%h, required 1 0 0", o_ready, o_valid, o_data);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_matrix("b2b_first", diag_mat(word_t'(34'h10000), 1'b0), -1);
        run_matrix("b2b_second", coupled_mat(), -1);
    endtask

    task automatic test_start_ignored();
        mat_t a, e;
        bit   ok;
        a = coupled_mat();
        model(a, e);
        load_matrix(a, -1, 0, ok);
        repeat (100) begin
            i_start = 1'b1;
            i_data  = rand_word();
            @(negedge clk);
        end
        i_start = 1'b0;
        i_data  = '0;
        collect("start_ignored", e);
    endtask

    task automatic test_div_zero();
        mat_t a;
        a = diag_mat('0, 1'b0);
        run_matrix("zero_matrix", a, -1);
        a = diag_mat(word_t'(34'h10000), 1'b0);
        a[ix(0, 0)] = '0;
        a[ix(1, 0)] = word_t'(34'h10000);
        a[ix(3, 0)] = word_t'(-34'sh20000);
        run_matrix("zero_pivot", a, -1);
    endtask

    task automatic test_random();
        mat_t a;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 6; i++)
                for (int j = 0; j <= i; j++)
                    a[ix(i, j)] = (i == j) ? word_t'($urandom_range(32'h80000, 32'h20000))
                                           : rand_small(32'h8000);
            run_matrix("random_spd", a, (t == 1) ? int'($urandom_range(20, 1)) : -1);
        end
        for (int w = 0; w < 21; w++) a[w] = rand_word();
        run_matrix("random_wide", a, -1);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_diag_ramp();
        test_coupled();
        test_pause();
        test_reset_mid();
        test_back_to_back();
        test_start_ignored();
        test_div_zero();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ldlt_decomp.md
Name: ldlt_decomp

Overview:
- Streaming fixed-point LDLᵀ factoriser for a symmetric n×n matrix, where n = 6·NODE_NUM.
- Loads the lower triangle of A, computes unit-lower-triangular L and diagonal D with A = L·D·Lᵀ, then streams the result out.
- Front-end factorisation stage of the linear-solver datapath.

Parameters:
- DATA_LEN, 34: word width; signed two's-complement fixed point.
- NODE_NUM, 1: node count; matrix dimension n = 6·NODE_NUM.
- FRACTION, 16: number of fractional bits (Q(DATA_LEN-FRACTION).FRACTION).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  load enable; a word is captured on each rising edge where i_start && o_ready.
- i_data  in  DATA_LEN  signed input element of A.
- o_ready  out  1  block can accept input (IDLE/LOAD).
- o_valid  out  1  o_data holds a valid result word.
- o_data  out  DATA_LEN  signed result element (L or D).

Behaviour:
- Sizes:
  - T = n(n+1)/2 words (21 for NODE_NUM=1).
  - Element order, input and output: row-major lower triangle, i = 0..n-1, j = 0..i. Word index = i(i+1)/2 + j.
- Storage: single T-entry triangular register file; results overwrite A in place.
- Reset values: o_ready=1, o_valid=0, o_data=0, state IDLE, all counters 0.
- States:
  - IDLE/LOAD (o_ready=1):
    - Each capture writes mem[cnt] and increments cnt.
    - If i_start drops mid-load, loading pauses and cnt holds; no timeout.
    - When the T-th word is captured, go to COMPUTE; o_ready=0 from the next cycle.
  - COMPUTE (o_ready=0, o_valid=0): process rows i ascending, and within each row j ascending:
    - For j<i: acc = A_ij − Σ_{k<j} fx_mul(fx_mul(L_jk, D_k), L_ik), k ascending. Then L_ij = fx_div(acc, D_j).
    - For j=i: D_i = A_ii − Σ_{k<i} fx_mul(fx_mul(L_ik, D_k), L_ik), k ascending.
  - OUTPUT:
    - T consecutive cycles with o_valid=1.
    - o_data = D_i at diagonal positions, L_ij at off-diagonal positions, in storage order.
    - Then o_valid=0, o_data=0, back to IDLE with o_ready=1 and cnt=0.
    - A new matrix may follow immediately.
- Arithmetic (bit-exact):
  - fx_mul(a,b): full 2·DATA_LEN-bit signed product, arithmetic shift right FRACTION, truncate to DATA_LEN.
  - fx_div(a,d): (a <<< FRACTION) / d as a signed quotient of 2·DATA_LEN-bit dividend, rounded toward zero, truncated to DATA_LEN.
  - If d = 0, the quotient is 0 and computation continues. No exception flag.
  - Accumulation wraps at DATA_LEN bits; no saturation anywhere.
- Latency:
  - One MAC per cycle plus one sequential divide per off-diagonal element.
  - First o_valid no later than 2000 cycles after the last capture for NODE_NUM=1.
  - Exact cycle count is implementation-defined but deterministic.
- Boundaries:
  - i_start asserted outside IDLE/LOAD is ignored.
  - rst_n asserted at any time, including mid-compute or mid-output, aborts immediately to reset values; partial data is discarded.

Decomposition:
- Package ldlt_pkg:
  - Default DATA_LEN and FRACTION.
  - fx_mul function.
  - State enum {IDLE, COMPUTE, OUTPUT}.
  - Triangular index helper tri_idx(i,j) = i(i+1)/2 + j.
- One sub-module, ldlt_fx_div:
  - Sequential signed restoring divider implementing fx_div.
  - Handshake start/done; d=0 yields 0.
- Top holds the storage, FSM, i/j/k counters and the MAC.

Test Plan:
- Identity 6×6: all diagonal words 0x10000, others 0.
  - Expect D_i = 0x10000 and all L_ij = 0, 21 consecutive o_valid words.
- diag(1.0..6.0): input words 0x10000, 0x20000, …, 0x60000 on the diagonal.
  - Expect D identical to the input diagonal and all L = 0.
- A_ii = 2.0 (0x20000) for all i, A_10 = 1.0 (0x10000), others 0.
  - Expect D0 = 0x20000, L10 = 0x08000, D1 = 0x18000, D2..D5 = 0x20000, remaining L = 0.
- Same stimulus with i_start low for 3 cycles after word 7.
  - Expect capture to pause and identical output.
  - Expect o_ready high throughout the pause and low after word 21.
- rst_n pulsed low during COMPUTE.
  - Expect o_ready=1, o_valid=0, o_data=0 immediately.
  - Expect a fresh identity load to produce the correct result.
- Two matrices back-to-back (identity, then the third scenario's matrix).
  - Expect both result streams correct.
  - Expect o_ready to return high in the cycle after the last output word.
